// File: rtl/axi_mem_pkg.sv
// Shared types and AXI constants for the burst memory slave and its masters.
// No logic; latency/backpressure are defined by the modules that import this.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_slave_mem_array.sv
// 1W/1R synchronous word array; read data registered, 1-cycle latency.
// No backpressure: rd_dat holds until the next rd_en; a same-edge write is not visible to that read.
module axi_slave_mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 256,
    parameter int INIT_OPTION = 0,
    localparam int IDX_W      = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    typedef logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] mem_t;

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < MEM_SIZE; i++) begin
            img[i] = (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
        end
        return img;
    endfunction

    // Contents are set once at time zero and deliberately survive rst_n.
    mem_t mem = init_image();

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi_memory_slave.sv
// AXI4-style INCR burst memory slave; independent write (AW/W/B) and read (AR/R) FSMs.
// R beats start 1 cycle after AR, 1 beat/cycle, held under rready=0; B follows wlast by 1 cycle.
module axi_memory_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int MEM_SIZE    = 256,
    parameter int INIT_OPTION = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam int OFF   = $clog2(DATA_WIDTH / 8);

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr >> OFF) % ADDR_WIDTH'(MEM_SIZE);
        return word[IDX_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(MEM_SIZE - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    wr_state_t        w_state;
    rd_state_t        r_state;
    logic [IDX_W-1:0] w_idx_q;
    logic [IDX_W-1:0] r_idx_q;
    logic [7:0]       aw_len_q;
    logic [7:0]       r_cnt_q;

    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;

    assign bresp = AXI_RESP_OKAY;
    assign wr_en = wvalid && wready;

    // r_idx_q always points at the word after the one currently on rdata.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = r_idx_q;
        if (r_state == R_IDLE) begin
            rd_en  = arvalid && arready;
            rd_idx = to_idx(araddr);
        end else if (rready && (r_cnt_q != 8'd0)) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_idx_q  <= '0;
            aw_len_q <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_idx_q  <= to_idx(awaddr);
                        aw_len_q <= awlen;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        w_state  <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_en) begin
                        w_idx_q <= next_idx(w_idx_q);
                        if (wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_idx_q <= '0;
            r_cnt_q <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_idx_q <= next_idx(to_idx(araddr));
                        r_cnt_q <= arlen;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                default: begin
                    if (rready) begin
                        if (r_cnt_q == 8'd0) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_idx_q <= next_idx(r_idx_q);
                            r_cnt_q <= r_cnt_q - 8'd1;
                            rlast   <= (r_cnt_q == 8'd1);
                        end
                    end
                end
            endcase
        end
    end

    // Burst length is taken from wlast; the latched awlen is kept only for visibility.
    logic unused_aw_len;
    assign unused_aw_len = ^{aw_len_q, 1'(ID_WIDTH)};

    axi_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .INIT_OPTION(INIT_OPTION)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .wr_idx(w_idx_q),
        .wr_dat(wdata),
        .rd_en (rd_en),
        .rd_idx(rd_idx),
        .rd_dat(rdata)
    );

endmodule

// File: tb/tb_axi_memory_slave.sv
module tb_axi_memory_slave;

    localparam int MS = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [MS];

    axi_memory_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_SIZE(MS), .INIT_OPTION(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % MS);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data[$],
                            input bit gaps, input int bdelay);
        int n;
        int idx;
        int waited;
        n   = data.size();
        idx = widx(addr);
        awaddr  = addr;
        awlen   = 8'(n - 1);
        awvalid = 1'b1;
        waited  = 0;
        while (awready !== 1'b1 && waited < 50) begin step(); waited++; end
        check("aw_handshake", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            wvalid = 1'b1;
            wdata  = data[i];
            wlast  = (i == n - 1);
            waited = 0;
            while (wready !== 1'b1 && waited < 50) begin step(); waited++; end
            check("w_ready", 32'(wready), 32'd1);
            step();
            model[idx] = data[i];
            idx = (idx + 1) % MS;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("bvalid_after_wlast", 32'(bvalid), 32'd1);
        check("bresp_okay", 32'(bresp), 32'd0);
        for (int k = 0; k < bdelay; k++) begin
            step();
            check("bvalid_held", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bvalid_cleared", 32'(bvalid), 32'd0);
        check("awready_back", 32'(awready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int n,
                           input int stall_beat, input bit rnd_stalls);
        int idx;
        int waited;
        int k;
        idx     = widx(addr);
        araddr  = addr;
        arlen   = 8'(n - 1);
        arvalid = 1'b1;
        waited  = 0;
        while (arready !== 1'b1 && waited < 50) begin step(); waited++; end
        check("ar_handshake", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        check("rvalid_first", 32'(rvalid), 32'd1);
        for (int i = 0; i < n; i++) begin
            k = 0;
            if (i == stall_beat) k = 3;
            else if (rnd_stalls && $urandom_range(0, 2) == 0) k = $urandom_range(1, 3);
            rready = 1'b0;
            for (int j = 0; j < k; j++) begin
                step();
                check("stall_rvalid", 32'(rvalid), 32'd1);
                check("stall_rdata", rdata, model[idx]);
                check("stall_rlast", 32'(rlast), 32'(i == n - 1));
            end
            rready = 1'b1;
            check("beat_rvalid", 32'(rvalid), 32'd1);
            check("beat_rdata", rdata, model[idx]);
            check("beat_rlast", 32'(rlast), 32'(i == n - 1));
            step();
            idx = (idx + 1) % MS;
        end
        rready = 1'b0;
        check("rvalid_done", 32'(rvalid), 32'd0);
        check("rlast_done", 32'(rlast), 32'd0);
        check("arready_back", 32'(arready), 32'd1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] a;
        int waited;

        for (int i = 0; i < MS; i++) model[i] = 32'(i);
        rst_n = 1'b0; awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wlast = 1'b0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        #12;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("leave_rst_awready", 32'(awready), 32'd1);
        check("leave_rst_arready", 32'(arready), 32'd1);

        // Basic burst and readback
        q = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(32'h0, q, 1'b0, 0);
        do_read(32'h0, 4, -1, 1'b0);
        check("t1_model_word3", model[3], 32'h44);

        // Init pattern
        do_read(32'h10, 8, -1, 1'b0);
        check("t2_model_word4", model[4], 32'd4);

        // Backpressure on both sides
        q = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
        do_write(32'h40, q, 1'b1, 2);
        do_read(32'h40, 4, 2, 1'b0);

        // Wrap from the top of the array
        q = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004};
        do_write(32'h3F8, q, 1'b0, 0);
        do_read(32'h0, 2, -1, 1'b0);
        check("t4_wrap_idx0", model[0], 32'hDEAD_0003);
        do_read(32'h3F8, 4, -1, 1'b0);

        // Concurrent AW and AR on disjoint regions
        q = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
        fork
            do_write(32'h100, q, 1'b0, 3);
            do_read(32'h180, 8, -1, 1'b1);
        join
        do_read(32'h100, 4, -1, 1'b0);

        // Reset in the middle of a write burst
        awaddr = 32'h200; awlen = 8'd3; awvalid = 1'b1;
        waited = 0;
        while (awready !== 1'b1 && waited < 50) begin step(); waited++; end
        check("t6_aw_handshake", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        wvalid = 1'b1;
        wdata = 32'h5555_0001;
        step();
        wdata = 32'h5555_0002;
        step();
        wvalid = 1'b0;
        model[128] = 32'h5555_0001;
        model[129] = 32'h5555_0002;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_awready", 32'(awready), 32'd0);
        check("t6_rst_wready", 32'(wready), 32'd0);
        check("t6_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_awready_after", 32'(awready), 32'd1);
        do_read(32'h200, 4, -1, 1'b0);
        q = '{32'h6666_0001, 32'h6666_0002, 32'h6666_0003};
        do_write(32'h204, q, 1'b0, 1);
        do_read(32'h200, 4, -1, 1'b0);

        // Randomized bursts against the array model
        for (int it = 0; it < 15; it++) begin
            a = $urandom;
            q = {};
            for (int b = 0; b < int'($urandom_range(1, 16)); b++) q.push_back($urandom);
            do_write(a, q, 1'b1, int'($urandom_range(0, 2)));
            do_read(a, q.size(), -1, 1'b1);
            do_read($urandom, int'($urandom_range(1, 8)), -1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
